// File: rtl/coin_acceptor_if.sv
// Coin-acceptor signal bundle: raw sensor lines and accept_en in, clean coin codes and status out.
// The coin_total member exists only when COIN_TOTAL_EN is defined.
interface coin_acceptor_if;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       accept_en;
  logic [1:0] coin_out;
  logic       fifo_empty;
  logic       overflow;
`ifdef COIN_TOTAL_EN
  logic [15:0] coin_total;

  modport master (
    output coin5_raw, coin10_raw, accept_en,
    input  coin_out, fifo_empty, overflow, coin_total
  );
  modport slave (
    input  coin5_raw, coin10_raw, accept_en,
    output coin_out, fifo_empty, overflow, coin_total
  );
`else
  modport master (
    output coin5_raw, coin10_raw, accept_en,
    input  coin_out, fifo_empty, overflow
  );
  modport slave (
    input  coin5_raw, coin10_raw, accept_en,
    output coin_out, fifo_empty, overflow
  );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: sync -> debounce -> rise detect -> coin FIFO -> registered coin_out pulse.
// Optional COIN_TOTAL_EN macro adds the 16-bit coin_total running sum.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic            clk,
  input logic            rst,
  coin_acceptor_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);

  // Index 0 is the five-unit line, index 1 the ten-unit line.
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d, deb_prev_q;
  logic [DbW-1:0] cnt_q [2];
  logic [DbW-1:0] cnt_d [2];
  logic [1:0]     rise;

  logic           mem_q [FIFO_DEPTH];
  logic           mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d, free;
  logic           pop, push5, push10;
  logic [1:0]     coin_out_q, coin_out_d;
  logic           ovf_q, ovf_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  always_comb begin
    pop    = bus.accept_en && (count_q != '0) && (coin_out_q == 2'b00);
    // A same-cycle pop makes room for this cycle's push.
    free   = CntW'(FIFO_DEPTH) - count_q + CntW'(pop);
    push5  = rise[0] && (free != '0);
    push10 = rise[1] && (free > CntW'(push5));
    ovf_d  = (rise[0] && !push5) || (rise[1] && !push10);

    mem_d = mem_q;
    if (push5)  mem_d[wr_ptr_q] = 1'b0;
    if (push10) mem_d[wr_ptr_q + PtrW'(push5)] = 1'b1;

    wr_ptr_d   = wr_ptr_q + PtrW'(push5) + PtrW'(push10);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_q - CntW'(pop) + CntW'(push5) + CntW'(push10);
    coin_out_d = pop ? (mem_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      // Debounced levels start high so a line held through reset never counts as a coin.
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      cnt_q      <= '{default: '0};
      mem_q      <= '{default: 1'b0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      coin_out_q <= 2'b00;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= {bus.coin10_raw, bus.coin5_raw};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      coin_out_q <= coin_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.coin_out   = coin_out_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_empty = (count_q == '0);

`ifdef COIN_TOTAL_EN
  logic [15:0] total_q, total_d;

  always_comb begin
    unique case (coin_out_q)
      2'b01:   total_d = total_q + 16'd5;
      2'b10:   total_d = total_q + 16'd10;
      default: total_d = total_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign bus.coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed and randomized bench for coin_acceptor; a queue-based coin model predicts every
// output cycle by cycle from clean-pulse latency and the pop/push rules.
module tb_coin_acceptor;

  localparam int unsigned DC    = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DC),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: queue of coins (0 = five, 1 = ten) and scheduled push edges.
  bit          mq[$];
  logic [1:0]  m_out   = 2'b00;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_total = 16'd0;
  bit   [1:0]  m_lvl   = 2'b00;
  bit          sched5[int];
  bit          sched10[int];

  logic [1:0]  win_codes[$];
  int          win_ovf;
  int          first_hit;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_win();
    win_codes.delete();
    win_ovf   = 0;
    first_hit = -1;
  endtask

  task automatic tick();
    bit r;
    bit acc;
    int nfree;
    r   = rst;
    acc = bus.accept_en;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mq.delete();
      sched5.delete();
      sched10.delete();
      m_out    = 2'b00;
      m_ovf    = 1'b0;
      m_total  = 16'd0;
      m_lvl[0] = bus.coin5_raw;
      m_lvl[1] = bus.coin10_raw;
    end else begin
      if (m_out == 2'b01) m_total = m_total + 16'd5;
      else if (m_out == 2'b10) m_total = m_total + 16'd10;
      if (acc && mq.size() > 0 && m_out == 2'b00) begin
        m_out = mq[0] ? 2'b10 : 2'b01;
        void'(mq.pop_front());
      end else begin
        m_out = 2'b00;
      end
      nfree = DEPTH - mq.size();
      m_ovf = 1'b0;
      if (sched5.exists(cyc)) begin
        if (nfree > 0) begin mq.push_back(1'b0); nfree--; end
        else m_ovf = 1'b1;
        sched5.delete(cyc);
      end
      if (sched10.exists(cyc)) begin
        if (nfree > 0) begin mq.push_back(1'b1); nfree--; end
        else m_ovf = 1'b1;
        sched10.delete(cyc);
      end
    end
    chk("coin_out", 16'(bus.coin_out), 16'(m_out));
    chk("overflow", 16'(bus.overflow), 16'(m_ovf));
    chk("fifo_empty", 16'(bus.fifo_empty), 16'(mq.size() == 0));
`ifdef COIN_TOTAL_EN
    chk("coin_total", bus.coin_total, m_total);
`endif
    if (bus.coin_out != 2'b00) begin
      win_codes.push_back(bus.coin_out);
      if (first_hit < 0) first_hit = cyc;
    end
    if (bus.overflow === 1'b1) win_ovf++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // A clean rise reaches the FIFO DC+3 edges after the raw change.
  task automatic raise(input int line);
    if (line == 0) begin
      bus.coin5_raw = 1'b1;
      if (!m_lvl[0]) sched5[cyc + DC + 3] = 1'b1;
      m_lvl[0] = 1'b1;
    end else begin
      bus.coin10_raw = 1'b1;
      if (!m_lvl[1]) sched10[cyc + DC + 3] = 1'b1;
      m_lvl[1] = 1'b1;
    end
  endtask

  task automatic lower(input int line);
    if (line == 0) begin bus.coin5_raw = 1'b0; m_lvl[0] = 1'b0; end
    else begin bus.coin10_raw = 1'b0; m_lvl[1] = 1'b0; end
  endtask

  initial begin
    int t0;
    int sel;
    int hi;
    int lo;
    logic [15:0] tot0;
    int seq3[5];
    seq3 = '{0, 1, 0, 1, 0};

    rst            = 1'b1;
    bus.coin5_raw  = 1'b0;
    bus.coin10_raw = 1'b0;
    bus.accept_en  = 1'b0;
    clear_win();
    run(2);
    chk("reset_empty", 16'(bus.fifo_empty), 16'd1);
    chk("reset_out", 16'(bus.coin_out), 16'd0);
    rst = 1'b0;
    run(10);

    // 1: single clean five, latency DC+4
    bus.accept_en = 1'b1;
    clear_win();
    raise(0);
    t0 = cyc;
    run(20);
    lower(0);
    run(12);
    chk("t1_latency", 16'(first_hit - t0), 16'(DC + 4));
    chk("t1_count", 16'(win_codes.size()), 16'd1);
    chk("t1_code", 16'(win_codes[0]), 16'd1);
    chk("t1_empty", 16'(bus.fifo_empty), 16'd1);

    // 2: bounces shorter than the debounce window
    clear_win();
    repeat (2) begin
      bus.coin10_raw = 1'b1; run(3);
      bus.coin10_raw = 1'b0; run(1);
      bus.coin10_raw = 1'b1; run(3);
      bus.coin10_raw = 1'b0; run(1);
    end
    run(12);
    chk("t2_count", 16'(win_codes.size()), 16'd0);
    chk("t2_ovf", 16'(win_ovf), 16'd0);

    // 3: five coins into a four-deep queue with accept_en low
    bus.accept_en = 1'b0;
    clear_win();
    foreach (seq3[i]) begin
      raise(seq3[i]);
      run(10);
      lower(seq3[i]);
      run(10);
    end
    chk("t3_ovf", 16'(win_ovf), 16'd1);
    chk("t3_held", 16'(win_codes.size()), 16'd0);
    bus.accept_en = 1'b1;
    clear_win();
    run(12);
    chk("t3_count", 16'(win_codes.size()), 16'd4);
    chk("t3_c0", 16'(win_codes[0]), 16'd1);
    chk("t3_c1", 16'(win_codes[1]), 16'd2);
    chk("t3_c2", 16'(win_codes[2]), 16'd1);
    chk("t3_c3", 16'(win_codes[3]), 16'd2);

    // 4: simultaneous five and ten
    clear_win();
`ifdef COIN_TOTAL_EN
    tot0 = bus.coin_total;
`else
    tot0 = 16'd0;
`endif
    raise(0);
    raise(1);
    run(20);
    lower(0);
    lower(1);
    run(12);
    chk("t4_count", 16'(win_codes.size()), 16'd2);
    chk("t4_first", 16'(win_codes[0]), 16'd1);
    chk("t4_second", 16'(win_codes[1]), 16'd2);
`ifdef COIN_TOTAL_EN
    chk("t4_total", bus.coin_total, tot0 + 16'd15);
`endif

    // 5: ten held high through reset
    raise(1);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear_win();
    run(30);
    chk("t5_no_coin", 16'(win_codes.size()), 16'd0);
    lower(1);
    run(10);
    clear_win();
    raise(1);
    run(15);
    lower(1);
    run(10);
    chk("t5_count", 16'(win_codes.size()), 16'd1);
    chk("t5_code", 16'(win_codes[0]), 16'd2);

    // 6: reset discards queued coins
    bus.accept_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raise(i % 2);
      run(10);
      lower(i % 2);
      run(10);
    end
    chk("t6_queued", 16'(bus.fifo_empty), 16'd0);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("t6_empty", 16'(bus.fifo_empty), 16'd1);
    chk("t6_out", 16'(bus.coin_out), 16'd0);
    bus.accept_en = 1'b1;
    clear_win();
    run(15);
    chk("t6_no_stale", 16'(win_codes.size()), 16'd0);

    // Randomized clean pulses with random accept_en
    repeat (16) begin
      sel = $urandom_range(0, 2);
      hi  = $urandom_range(6, 10);
      lo  = $urandom_range(8, 12);
      if (sel != 1) raise(0);
      if (sel != 0) raise(1);
      repeat (hi) begin
        bus.accept_en = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        tick();
      end
      if (sel != 1) lower(0);
      if (sel != 0) lower(1);
      repeat (lo) begin
        bus.accept_en = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
        tick();
      end
    end
    bus.accept_en = 1'b1;
    run(20);
    chk("final_empty", 16'(bus.fifo_empty), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
